nrzi_frame_decoder: RTL and testbench

NRZI_FRAME_DECODER -- requirements
Module: nrzi_frame_decoder

---
 rtl/nrzi_frame_decoder.sv | 142 ++++++++++++++
 tb/tb_nrzi_frame_decoder.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/nrzi_frame_decoder.sv
// NRZI line decoder with flag framing: recovers bits, aligns bytes to FLAG, reports frame boundaries.
// Define NRZI_DESTUFF_EN to enable zero-bit destuffing, run-of-ones flag detection and abort reporting.
module nrzi_frame_decoder #(
   parameter logic [7:0] FLAG      = 8'h7E,
   parameter logic       LINE_IDLE = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       line_in,
   input  logic       bit_en,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       frame_start,
   output logic       frame_end,
   output logic       abort_err,
   output logic       in_frame
);

   typedef enum logic [1:0] {HUNT, OPEN, DATA} state_t;

   state_t     state, state_nx;
   logic       prev_line;
   logic [2:0] bitcnt, bitcnt_nx;
   logic [6:0] byte_sr, byte_sr_nx;
   logic [7:0] data_nx;
   logic       dv_nx, fs_nx, fe_nx;

   logic       dbit;
   logic [7:0] shifted;
   logic       aligned;
   logic       flag_evt;
   logic       abort_evt;
   logic       keep_bit;

   // byte_sr holds the 7 most recent kept bits; the current bit completes the byte.
   assign dbit    = line_in ^ prev_line;
   assign shifted = {dbit, byte_sr};
   assign aligned = (bitcnt == 3'd7) && (shifted == FLAG);

`ifdef NRZI_DESTUFF_EN
   logic [4:0] ones;
   logic       ab_nx;

   assign abort_evt = dbit && (ones == 5'd6);
   assign flag_evt  = !dbit && (ones == 5'd6);
   assign keep_bit  = !(!dbit && (ones == 5'd5));

   // Saturating run length so a long run of 1s aborts only once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ones      <= 5'd0;
         abort_err <= 1'b0;
      end else begin
         abort_err <= ab_nx;
         if (bit_en) begin
            if (!dbit)
               ones <= 5'd0;
            else if (ones != 5'd31)
               ones <= ones + 5'd1;
         end
      end
   end
`else
   assign abort_evt = 1'b0;
   assign keep_bit  = 1'b1;
   // In HUNT any 8-bit window may match; once synced only byte boundaries count.
   assign flag_evt  = (state == HUNT) ? (shifted == FLAG) : aligned;
   assign abort_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= HUNT;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      bitcnt_nx  = bitcnt;
      byte_sr_nx = byte_sr;
      data_nx    = data_out;
      dv_nx      = 1'b0;
      fs_nx      = 1'b0;
      fe_nx      = 1'b0;
`ifdef NRZI_DESTUFF_EN
      ab_nx      = 1'b0;
`endif
      if (bit_en) begin
         if (abort_evt) begin
`ifdef NRZI_DESTUFF_EN
            ab_nx = 1'b1;
`endif
            state_nx  = HUNT;
            bitcnt_nx = 3'd0;
         end else if (flag_evt) begin
            bitcnt_nx = 3'd0;
            state_nx  = OPEN;
            if (state == DATA && aligned) begin
               fe_nx = 1'b1;
            end else if (state != HUNT && !aligned) begin
`ifdef NRZI_DESTUFF_EN
               ab_nx = 1'b1;
`endif
            end
         end else if (keep_bit) begin
            byte_sr_nx = shifted[7:1];
            bitcnt_nx  = bitcnt + 3'd1;
            if (bitcnt == 3'd7 && state != HUNT) begin
               data_nx  = shifted;
               dv_nx    = 1'b1;
               fs_nx    = (state == OPEN);
               state_nx = DATA;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_line   <= LINE_IDLE;
         bitcnt      <= 3'd0;
         byte_sr     <= 7'd0;
         data_out    <= 8'h00;
         data_valid  <= 1'b0;
         frame_start <= 1'b0;
         frame_end   <= 1'b0;
         in_frame    <= 1'b0;
      end else begin
         if (bit_en)
            prev_line <= line_in;
         bitcnt      <= bitcnt_nx;
         byte_sr     <= byte_sr_nx;
         data_out    <= data_nx;
         data_valid  <= dv_nx;
         frame_start <= fs_nx;
         frame_end   <= fe_nx;
         in_frame    <= (state_nx == DATA);
      end
   end

endmodule

// File: tb/tb_nrzi_frame_decoder.sv
// Directed bench for nrzi_frame_decoder: byte-vector table plus reset and destuffing sequences.
module tb_nrzi_frame_decoder;

   logic       clk     = 1'b0;
   logic       rst     = 1'b1;
   logic       line_in = 1'b0;
   logic       bit_en  = 1'b0;
   logic [7:0] data_out;
   logic       data_valid, frame_start, frame_end, abort_err, in_frame;

   nrzi_frame_decoder #(.FLAG(8'h7E), .LINE_IDLE(1'b0)) dut (
      .clk(clk), .rst(rst), .line_in(line_in), .bit_en(bit_en),
      .data_out(data_out), .data_valid(data_valid), .frame_start(frame_start),
      .frame_end(frame_end), .abort_err(abort_err), .in_frame(in_frame)
   );

   always #5 clk = ~clk;

   // pulses = {data_valid, frame_start, frame_end, abort_err}
   typedef struct {
      logic [7:0] din;
      logic [3:0] pulses;
      logic [7:0] dout;
      logic       inf;
   } vec_t;

   vec_t tbl [11];
   int   checks = 0;
   int   errors = 0;
   int   gap    = 0;
   logic line_lvl = 1'b0;
   logic idle_bad = 1'b0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] cur_pulses();
      return {data_valid, frame_start, frame_end, abort_err};
   endfunction

   // One NRZI bit: a 1 toggles the line. Idle cycles after it must carry no pulses.
   task automatic send_bit(input logic b, output logic [3:0] p);
      bit_en   = 1'b1;
      line_lvl = line_lvl ^ b;
      line_in  = line_lvl;
      @(posedge clk); #1;
      p      = cur_pulses();
      bit_en = 1'b0;
      for (int g = 0; g < gap; g++) begin
         @(posedge clk); #1;
         if (cur_pulses() != 4'b0000) idle_bad = 1'b1;
      end
   endtask

   task automatic send_seq(input logic [15:0] bits, input int n,
                           output logic [3:0] plast, output logic early);
      logic [3:0] p;
      early = 1'b0;
      plast = 4'b0000;
      for (int i = 0; i < n; i++) begin
         send_bit(bits[i], p);
         if (i == n - 1) plast = p;
         else if (p != 4'b0000) early = 1'b1;
      end
   endtask

   task automatic check_seq(input string name, input logic [15:0] bits, input int n,
                            input logic [3:0] exp_p, input logic [7:0] exp_dout, input logic exp_inf);
      logic [3:0] plast;
      logic       early;
      idle_bad = 1'b0;
      send_seq(bits, n, plast, early);
      chk({name, "_pulses"}, {4'b0000, plast}, {4'b0000, exp_p});
      chk({name, "_early"}, {7'd0, early}, 8'd0);
      chk({name, "_dout"}, data_out, exp_dout);
      chk({name, "_in_frame"}, {7'd0, in_frame}, {7'd0, exp_inf});
      if (gap > 0) chk({name, "_idle"}, {7'd0, idle_bad}, 8'd0);
   endtask

   // Reset held across an edge with bit_en=1 and a line transition: reset must win.
   task automatic do_reset();
      rst     = 1'b1;
      bit_en  = 1'b1;
      line_in = ~line_in;
      #1;
      chk("rst_async_pulses", {4'b0000, cur_pulses()}, 8'd0);
      @(posedge clk); #1;
      chk("rst_dout", data_out, 8'h00);
      chk("rst_pulses", {4'b0000, cur_pulses()}, 8'd0);
      chk("rst_in_frame", {7'd0, in_frame}, 8'd0);
      rst      = 1'b0;
      bit_en   = 1'b0;
      line_lvl = 1'b0;
      line_in  = 1'b0;
      @(posedge clk); #1;
      chk("rst_release_pulses", {3'd0, cur_pulses(), in_frame}, 8'd0);
   endtask

   initial begin
      logic [3:0] p;
      logic       early;

      tbl[0]  = '{8'h7E, 4'b0000, 8'h00, 1'b0};
      tbl[1]  = '{8'h12, 4'b1100, 8'h12, 1'b1};
      tbl[2]  = '{8'h34, 4'b1000, 8'h34, 1'b1};
      tbl[3]  = '{8'h7E, 4'b0010, 8'h34, 1'b0};
      tbl[4]  = '{8'h7E, 4'b0000, 8'h34, 1'b0};
      tbl[5]  = '{8'h7E, 4'b0000, 8'h34, 1'b0};
      tbl[6]  = '{8'hA5, 4'b1100, 8'hA5, 1'b1};
      tbl[7]  = '{8'h7E, 4'b0010, 8'hA5, 1'b0};
      tbl[8]  = '{8'h00, 4'b1100, 8'h00, 1'b1};
      tbl[9]  = '{8'h81, 4'b1000, 8'h81, 1'b1};
      tbl[10] = '{8'h7E, 4'b0010, 8'h81, 1'b0};

      repeat (2) @(posedge clk);
      #1;
      chk("init_dout", data_out, 8'h00);
      chk("init_pulses", {4'b0000, cur_pulses()}, 8'd0);
      chk("init_in_frame", {7'd0, in_frame}, 8'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Pass 0: bit_en every cycle. Pass 1: bit_en every third cycle.
      for (int r = 0; r < 2; r++) begin
         gap = (r == 0) ? 0 : 2;
         if (r == 1) do_reset();
         for (int k = 0; k < 11; k++)
            check_seq($sformatf("p%0d_v%0d", r, k), {8'h00, tbl[k].din}, 8,
                      tbl[k].pulses, tbl[k].dout, tbl[k].inf);
      end

      // Reset in the middle of a byte inside DATA.
      gap = 0;
      check_seq("mf_55", 16'h0055, 8, 4'b1100, 8'h55, 1'b1);
      send_seq(16'h0006, 4, p, early);
      chk("mf_partial", {3'd0, early, p}, 8'd0);
      do_reset();
      check_seq("mf_ignored", 16'h0012, 8, 4'b0000, 8'h00, 1'b0);
      check_seq("mf_flag", 16'h007E, 8, 4'b0000, 8'h00, 1'b0);
      check_seq("mf_resync", 16'h0012, 8, 4'b1100, 8'h12, 1'b1);

`ifdef NRZI_DESTUFF_EN
      check_seq("ds_close", 16'h007E, 8, 4'b0010, 8'h12, 1'b0);
      check_seq("ds_3f", 16'h005F, 9, 4'b1100, 8'h3F, 1'b1);
      check_seq("ds_7e_data", 16'h00BE, 9, 4'b1000, 8'h7E, 1'b1);
      for (int i = 0; i < 8; i++) begin
         send_bit(1'b1, p);
         chk($sformatf("ds_ones%0d", i), {4'b0000, p}, (i == 6) ? 8'h01 : 8'h00);
      end
      chk("ds_abort_in_frame", {7'd0, in_frame}, 8'd0);
      check_seq("ds_zero", 16'h0000, 1, 4'b0000, 8'h7E, 1'b0);
      check_seq("ds_ignored", 16'h0034, 8, 4'b0000, 8'h7E, 1'b0);
      check_seq("ds_flag", 16'h007E, 8, 4'b0000, 8'h7E, 1'b0);
      check_seq("ds_resync", 16'h0034, 8, 4'b1100, 8'h34, 1'b1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
